// File: rtl/tc_decoder_pkg.sv
// Shared decoder definitions: step direction codes and the one-hot decode helper.
package tc_decoder_pkg;

    // Largest supported select width and the matching decode width
    localparam int MAX_SEL_WIDTH = 8;
    localparam int MAX_OUT_COUNT = 2 ** MAX_SEL_WIDTH;

    // Step direction encodings for the 'down' input
    localparam logic STEP_UP   = 1'b0;
    localparam logic STEP_DOWN = 1'b1;

    // Index to one-hot at full width; callers truncate to their own output count
    function automatic logic [MAX_OUT_COUNT-1:0] onehot_decode(input logic [MAX_SEL_WIDTH-1:0] idx);
        onehot_decode = MAX_OUT_COUNT'(1) << idx;
    endfunction

endpackage

// File: rtl/tc_onehot_decoder.sv
// Combinational index-to-one-hot decode with an output disable gate.
module tc_onehot_decoder
    import tc_decoder_pkg::*;
#(
    parameter int SEL_WIDTH = 3
) (
    input  logic [SEL_WIDTH-1:0]      i_index,
    input  logic                      i_dis,
    output logic [(2**SEL_WIDTH)-1:0] o_out
);

    localparam int OUT_COUNT = 2 ** SEL_WIDTH;

    logic [OUT_COUNT-1:0] w_dec;

    // Decode the index, then force every line low while disabled
    always_comb begin
        w_dec = OUT_COUNT'(onehot_decode(MAX_SEL_WIDTH'(i_index)));
        o_out = i_dis ? '0 : w_dec;
    end

endmodule

// File: rtl/tc_step_decoder.sv
// Stateful decoder: a registered index that loads or steps up/down with
// wrap or saturate at the ends, decoded to gated one-hot select lines.
module tc_step_decoder
    import tc_decoder_pkg::*;
#(
    parameter int SEL_WIDTH = 3,
    parameter int WRAP      = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_dis,
    input  logic                      i_load,
    input  logic [SEL_WIDTH-1:0]      i_sel,
    input  logic                      i_step,
    input  logic                      i_down,
    output logic [(2**SEL_WIDTH)-1:0] o_out,
    output logic [SEL_WIDTH-1:0]      o_index,
    output logic                      o_edge_hit
);

    localparam logic [SEL_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [SEL_WIDTH-1:0] IDX_MIN = '0;

    logic [SEL_WIDTH-1:0] r_index;
    logic                 r_edge_hit;

    // Index/edge state: reset beats load beats step; idle clears the edge pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_index    <= '0;
            r_edge_hit <= 1'b0;
        end else if (i_load) begin
            r_index    <= i_sel;
            r_edge_hit <= 1'b0;
        end else if (i_step) begin
            if (i_down == STEP_UP) begin
                if (r_index != IDX_MAX) begin
                    r_index    <= r_index + 1'b1;
                    r_edge_hit <= 1'b0;
                end else begin
                    // At the top: wrap to zero or stay put, flag either way
                    if (WRAP != 0) r_index <= IDX_MIN;
                    r_edge_hit <= 1'b1;
                end
            end else begin
                if (r_index != IDX_MIN) begin
                    r_index    <= r_index - 1'b1;
                    r_edge_hit <= 1'b0;
                end else begin
                    // At the bottom: wrap to max or stay put, flag either way
                    if (WRAP != 0) r_index <= IDX_MAX;
                    r_edge_hit <= 1'b1;
                end
            end
        end else begin
            r_edge_hit <= 1'b0;
        end
    end

    assign o_index    = r_index;
    assign o_edge_hit = r_edge_hit;

    tc_onehot_decoder #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_dec (
        .i_index (r_index),
        .i_dis   (i_dis),
        .o_out   (o_out)
    );

endmodule

// File: doc/tc_step_decoder.md
# tc_step_decoder

Parametrised, stateful successor to the fixed 3-to-8 decoder. It holds a registered select index that can be loaded directly or stepped up or down, with wrap or saturate at the ends. It drives a one-hot output of `2**SEL_WIDTH` lines, gated by a disable input. It is used as a sequencer and round-robin pointer for register-file and bus-select fabrics, and as a drop-in decoder when only `load` is used.

## Interface
Parameters:
- `SEL_WIDTH`, default 3: select and index width; output count is `OUT_COUNT = 2**SEL_WIDTH`, a derived localparam. Legal range is 1..8.
- `WRAP`, default 1: 1 means stepping past either end wraps; 0 means it saturates at the end.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `dis`  in  1: disable; forces all `out` bits low, combinationally. Does not affect state.
- `load`  in  1: load `sel` into the index.
- `sel`  in  SEL_WIDTH: value to load.
- `step`  in  1: advance the index by one.
- `down`  in  1: step direction; 0 = increment, 1 = decrement.
- `out`  out  OUT_COUNT: one-hot decode of the index; all zero when `dis` = 1.
- `index`  out  SEL_WIDTH: current registered index.
- `edge_hit`  out  1: registered; high for one cycle after a step that wrapped (WRAP=1) or was blocked at an end (WRAP=0).

## Operation
- Priority at each rising edge: `rst` > `load` > `step` > hold.
- `rst`: `index` ← 0 and `edge_hit` ← 0.
- `load`: `index` ← `sel` and `edge_hit` ← 0. A `step` in the same cycle is ignored.
- `step` with `down`=0:
  - If `index` < max: `index` ← `index`+1, `edge_hit` ← 0.
  - If `index` = max and WRAP=1: `index` ← 0, `edge_hit` ← 1.
  - If `index` = max and WRAP=0: `index` holds, `edge_hit` ← 1.
- `step` with `down`=1 mirrors this:
  - If `index` > 0: `index` ← `index`−1, `edge_hit` ← 0.
  - If `index` = 0 and WRAP=1: `index` ← max, `edge_hit` ← 1.
  - If `index` = 0 and WRAP=0: `index` holds, `edge_hit` ← 1.
- Idle cycle (no `load`, no `step`): `index` holds and `edge_hit` ← 0.
- `out[i]` = (`index` == i) && !`dis`. Exactly one bit is high when enabled; all bits are zero when disabled.
- `dis` never blocks `load` or `step`. The index keeps moving while the outputs are gated.
- Index arithmetic is modulo `2**SEL_WIDTH` in WRAP mode. There is no X-propagation path: `sel` is used only when `load`=1.

## Timing
- Reset values: `index` = 0, `edge_hit` = 0. `out` = 1 (bit 0 set) if `dis`=0 and 0 if `dis`=1.
- Latency:
  - `load` or `step` to `index` and `out`: 1 cycle, registered.
  - `dis` to `out`: 0 cycles, combinational.
  - A step that wraps or is blocked to `edge_hit`: 1 cycle. `edge_hit` is one cycle wide per event.
- Back-to-back steps advance once per cycle. Consecutive wrapping steps assert `edge_hit` on every such cycle.
- `rst` asserted mid-sequence overrides a concurrent `load` or `step`. The next cycle shows `index`=0.
- `SEL_WIDTH`=1: max=1, two outputs, and the same rules apply.

## Structure
- Shared package `tc_decoder_pkg` holds:
  - the `onehot_decode` function (index → one-hot vector, parametrised width);
  - the `STEP_UP`/`STEP_DOWN` direction constants.
- Sub-module `tc_onehot_decoder` is the combinational, parametrised decode plus disable gating. `tc_step_decoder` instantiates it on the registered `index`.
- All state lives in one `always` block on `clk`, covering `index` and `edge_hit`.

## Test plan
- Reset and gating, with SEL_WIDTH=3: assert `rst` for 2 cycles, then release.
  - Expect `index`=0, `out`=8'h01, `edge_hit`=0.
  - Then hold `dis`=1: `out`=8'h00 in the same cycle, and `index` is unchanged.
- Load, with SEL_WIDTH=3: `load`=1, `sel`=5 → next cycle `index`=5, `out`=8'h20.
  - Then `load`=1 with `step`=1 and `sel`=2 → `index`=2, because the step is ignored.
- Wrap up, with WRAP=1: load 7, then `step`=1, `down`=0 → `index`=0, `out`=8'h01, and `edge_hit`=1 for exactly one cycle.
  - A further step gives `index`=1 with `edge_hit`=0.
- Wrap down and saturate:
  - WRAP=1, `index`=0, step down → `index`=7 and `edge_hit` pulses.
  - WRAP=0, `index`=7, three up-steps → `index` stays 7 and `edge_hit`=1 on all three cycles.
  - WRAP=0, `index`=0, step down → `index` stays 0 and `edge_hit` pulses.
- Disable while stepping, with SEL_WIDTH=3: `dis`=1 for 4 up-steps from 0.
  - `out`=0 throughout and `index` reaches 4.
  - Drop `dis` → `out`=8'h10 in the same cycle.
- Reset mid-operation and width sweep:
  - At `index`=6, assert `rst` together with `step` → `index`=0 and `edge_hit`=0.
  - Repeat the load/step/wrap checks with SEL_WIDTH=1 (`out` 2'b01↔2'b10) and SEL_WIDTH=4 (load 15, step → 0 with a pulse).
